rega_timer_ctrl: RTL and testbench

Irrigation-cycle sequencer for the automatic watering system. Accepts a two-digit BCD watering duration, opens the valve, and counts the duration down through a units/tens decade down-counter pair on a one-cycle time-base strobe. It closes the valve at zero or on abort, and reports completion and errors. It sits between the panel/sensor logic and the valve driver, and owns the digit counters that feed the display.

---
 rtl/rega_pkg.sv | 7 +
 rtl/bcd_digit_down.sv | 16 +
 rtl/rega_timer_ctrl.sv | 74 +++++++
 tb/tb_rega_timer_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/rega_pkg.sv
// rega_pkg: shared types and constants for the irrigation-cycle sequencer.
package rega_pkg;
    typedef logic [3:0] bcd_t;
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
    localparam bcd_t BCD_MAX = 4'd9;
    localparam bcd_t BCD_ZERO = 4'd0;
endpackage

// File: rtl/bcd_digit_down.sv
// bcd_digit_down: one BCD decade down-counter with load and borrow-out.
module bcd_digit_down import rega_pkg::*; (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  bcd_t val,
    input  logic en,
    output bcd_t digit,
    output logic borrow
);
    assign borrow = en && digit == BCD_ZERO;
    always_ff @(posedge clk)
        if (rst) digit <= BCD_ZERO;
        else if (load) digit <= val;
        else if (en) digit <= borrow ? BCD_MAX : digit - 4'd1;
endmodule

// File: rtl/rega_timer_ctrl.sv
// rega_timer_ctrl: watering-cycle sequencer driving the valve from a BCD countdown.
// Rain pause is compiled in with REGA_RAIN_PAUSE_EN.
module rega_timer_ctrl import rega_pkg::*; (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic start,
    input  logic stop,
    input  logic dry,
    input  logic rain,
    input  bcd_t dur_t,
    input  bcd_t dur_u,
    output logic valve,
    output logic busy,
    output logic done,
    output logic err,
    output bcd_t cnt_t,
    output bcd_t cnt_u
);
    state_t state, state_n;
    logic pause_req, bad, zero, go, abort, en_u, bor_u, bor_t, last, load;
    logic valve_n, busy_n, done_n, err_n;
`ifdef REGA_RAIN_PAUSE_EN
    assign pause_req = rain;
`else
    assign pause_req = rain & 1'b0;
`endif
    assign bad = dur_t > BCD_MAX || dur_u > BCD_MAX;
    assign zero = dur_t == BCD_ZERO && dur_u == BCD_ZERO;
    assign go = state == IDLE && start && !bad && dry && !zero;
    assign abort = (state == RUN || state == PAUSE) && stop;
    assign en_u = state == RUN && tick && !stop && !pause_req;
    assign last = cnt_t == BCD_ZERO && cnt_u == 4'd1;
    // a tens borrow would mean counting below 00: clamp by reloading zeros
    assign load = go || abort || bor_t;
    bcd_digit_down u_units (
        .clk(clk), .rst(rst), .load(load), .val(go ? dur_u : BCD_ZERO),
        .en(en_u), .digit(cnt_u), .borrow(bor_u)
    );
    bcd_digit_down u_tens (
        .clk(clk), .rst(rst), .load(load), .val(go ? dur_t : BCD_ZERO),
        .en(bor_u), .digit(cnt_t), .borrow(bor_t)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            valve <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
        end else begin
            state <= state_n;
            valve <= valve_n;
            busy <= busy_n;
            done <= done_n;
            err <= err_n;
        end
    end
    always_comb begin
        state_n = IDLE;
        case (state)
            IDLE:    state_n = go ? RUN : IDLE;
            RUN:     state_n = stop ? IDLE : pause_req ? PAUSE : (tick && last) ? DONE : RUN;
            PAUSE:   state_n = stop ? IDLE : pause_req ? PAUSE : RUN;
            default: state_n = IDLE;
        endcase
    end
    always_comb begin
        valve_n = state_n == RUN;
        busy_n = state_n == RUN || state_n == PAUSE;
        done_n = state_n == DONE || (state == IDLE && start && !bad && dry && zero);
        err_n = state == IDLE && start && bad;
    end
endmodule

// File: tb/tb_rega_timer_ctrl.sv
// tb_rega_timer_ctrl: scoreboard bench with directed scenarios and random traffic.
module tb_rega_timer_ctrl;
`ifdef REGA_RAIN_PAUSE_EN
    localparam bit PE = 1'b1;
`else
    localparam bit PE = 1'b0;
`endif
    typedef struct packed {
        logic valve, busy, done, err;
        logic [3:0] ct, cu;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1, tick = 1'b0, start = 1'b0, stop = 1'b0, dry = 1'b1, rain = 1'b0;
    logic [3:0] dur_t = 4'd0, dur_u = 4'd0;
    logic valve, busy, done, err;
    logic [3:0] cnt_t, cnt_u;
    exp_t q[$];
    int n_chk = 0, n_fail = 0;
    rega_timer_ctrl dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop), .dry(dry),
        .rain(rain), .dur_t(dur_t), .dur_u(dur_u), .valve(valve), .busy(busy),
        .done(done), .err(err), .cnt_t(cnt_t), .cnt_u(cnt_u)
    );
    always #5 clk = ~clk;
    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask
    // reference: remaining time as a plain integer, mode 0 idle 1 watering 2 paused 3 finishing
    initial begin
        int rem, mode, d;
        logic pd, pe;
        rem = 0;
        mode = 0;
        forever begin
            @(posedge clk);
            pd = 1'b0;
            pe = 1'b0;
            d = int'(dur_t) * 10 + int'(dur_u);
            if (rst) begin
                mode = 0;
                rem = 0;
            end else if (mode == 0) begin
                if (start) begin
                    if (dur_t > 9 || dur_u > 9) pe = 1'b1;
                    else if (dry && d == 0) pd = 1'b1;
                    else if (dry) begin
                        rem = d;
                        mode = 1;
                    end
                end
            end else if (mode == 3) mode = 0;
            else if (stop) begin
                mode = 0;
                rem = 0;
            end else if (mode == 1) begin
                if (PE && rain) mode = 2;
                else if (tick) begin
                    rem = rem - 1;
                    if (rem == 0) mode = 3;
                end
            end else if (!rain) mode = 1;
            q.push_back('{mode == 1, mode == 1 || mode == 2, mode == 3 || pd, pe,
                          4'(rem / 10), 4'(rem % 10)});
        end
    end
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() == 0) check("queue_underflow", 0, 1);
            else begin
                e = q.pop_front();
                check("valve", valve, e.valve);
                check("busy", busy, e.busy);
                check("done", done, e.done);
                check("err", err, e.err);
                check("cnt", {cnt_t, cnt_u}, {e.ct, e.cu});
                check("done_err_excl", done && err, 0);
            end
        end
    end
    task automatic step(input logic r, tk, st, sp, dy, rn, input logic [3:0] t, u);
        @(negedge clk);
        rst = r;
        tick = tk;
        start = st;
        stop = sp;
        dry = dy;
        rain = rn;
        dur_t = t;
        dur_u = u;
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1, 0, 0, 0);
    endtask
    task automatic go(input logic [3:0] t, u);
        step(0, 0, 1, 0, 1, 0, t, u);
    endtask
    task automatic ticks(input int n, input logic rn);
        for (int i = 0; i < n; i++) begin
            step(0, 1, 0, 0, 1, rn, 0, 0);
            step(0, 0, 0, 0, 1, rn, 0, 0);
        end
    endtask
    initial begin
        logic rn;
        logic [3:0] t, u;
        step(1, 0, 0, 0, 1, 0, 0, 0);
        step(1, 1, 1, 0, 1, 0, 1, 1);
        idle(2);
        go(1, 0);
        ticks(10, 0);
        idle(3);
        step(0, 0, 1, 0, 1, 0, 0, 4'hA);
        idle(1);
        step(0, 0, 1, 0, 0, 0, 4'hC, 3);
        idle(1);
        go(0, 0);
        idle(1);
        step(0, 0, 1, 0, 0, 0, 3, 7);
        idle(2);
        step(0, 1, 1, 0, 1, 0, 1, 5);
        ticks(10, 0);
        step(0, 1, 0, 1, 1, 0, 0, 0);
        idle(3);
        go(2, 5);
        ticks(5, 0);
        step(0, 0, 1, 0, 1, 0, 9, 9);
        ticks(20, 0);
        idle(2);
        go(5, 0);
        ticks(13, 0);
        step(1, 1, 0, 0, 1, 0, 0, 0);
        idle(1);
        go(0, 3);
        ticks(3, 0);
        idle(2);
        go(2, 0);
        ticks(8, 0);
        ticks(5, 1);
        ticks(12, 0);
        idle(3);
        step(0, 0, 1, 0, 1, 1, 0, 2);
        ticks(3, 1);
        ticks(2, 0);
        idle(2);
        rn = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) rn = !rn;
            t = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 2));
            u = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            step($urandom_range(0, 499) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 59) == 0, $urandom_range(0, 5) != 0, rn, t, u);
        end
        idle(3);
        @(posedge clk);
        #2;
        check("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
